// File: rtl/alu_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_pkg
//  Purpose  : Shared definitions for the ALU command sequencer: FSM state
//             encoding, command opcodes and ALU function codes (the function
//             codes are also used by the ALU and its bench).
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_cmd_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GET_A    = 3'd1,
      GET_B    = 3'd2,
      GET_FUN  = 3'd3,
      ISSUE    = 3'd4,
      WAIT_RES = 3'd5,
      SEND_LO  = 3'd6,
      SEND_HI  = 3'd7
   } state_t;

   // Command opcodes
   localparam logic [7:0] OPC_ALU_FULL = 8'hCC;   // carries A, B and FUN
   localparam logic [7:0] OPC_ALU_FUN  = 8'hDD;   // carries FUN only

   // ALU function codes
   localparam logic [3:0] FUN_ADD    = 4'd0;
   localparam logic [3:0] FUN_SUB    = 4'd1;
   localparam logic [3:0] FUN_MUL    = 4'd2;
   localparam logic [3:0] FUN_DIV    = 4'd3;
   localparam logic [3:0] FUN_AND    = 4'd4;
   localparam logic [3:0] FUN_OR     = 4'd5;
   localparam logic [3:0] FUN_NAND   = 4'd6;
   localparam logic [3:0] FUN_NOR    = 4'd7;
   localparam logic [3:0] FUN_XOR    = 4'd8;
   localparam logic [3:0] FUN_XNOR   = 4'd9;
   localparam logic [3:0] FUN_CMPEQ  = 4'd10;
   localparam logic [3:0] FUN_CMPGT  = 4'd11;
   localparam logic [3:0] FUN_CMPLT  = 4'd12;
   localparam logic [3:0] FUN_PASSA  = 4'd13;
   localparam logic [3:0] FUN_SHL    = 4'd14;
   localparam logic [3:0] FUN_SHR    = 4'd15;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_tx_ser.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_tx_ser
//  Purpose  : Two-byte result serialiser. A load strobe captures the result
//             and presents the low byte, then the high byte, on a valid/ready
//             handshake. done pulses when the high byte transfers.
//  Ports    : CLK, RST          - clock, async active-high reset
//             load, load_data   - start strobe and 2*DATA_WIDTH result
//             tx_data, tx_vld   - byte and valid towards the TX path
//             tx_ready          - TX ready; transfer on tx_vld && tx_ready
//             done              - high byte transferring this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_tx_ser #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    load,
   input  logic [2*DATA_WIDTH-1:0] load_data,
   input  logic                    tx_ready,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic                    tx_vld,
   output logic                    done
);

   logic [2*DATA_WIDTH-1:0] result;
   logic                    hi_sel;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         result <= '0;
         tx_vld <= 1'b0;
         hi_sel <= 1'b0;
      end else if (load) begin
         result <= load_data;
         tx_vld <= 1'b1;
         hi_sel <= 1'b0;
      end else if (tx_vld && tx_ready) begin
         if (hi_sel) begin
            tx_vld <= 1'b0;
            hi_sel <= 1'b0;
         end else begin
            hi_sel <= 1'b1;
         end
      end
   end

   // Mux from registers only, so the byte is stable while stalled.
   assign tx_data = hi_sel ? result[2*DATA_WIDTH-1:DATA_WIDTH] : result[DATA_WIDTH-1:0];
   assign done    = tx_vld && tx_ready && hi_sel;

endmodule
`default_nettype wire

// File: rtl/alu_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_seq
//  Purpose  : Command-side ALU initiator. Parses byte-framed commands from
//             the UART RX path, drives ALU operands/function/enable, gates
//             the ALU clock, captures the result and streams it as two bytes
//             (low first) to the UART TX path.
//  Option   : CMD_TIMEOUT_EN - adds a result watchdog (TIMEOUT_CYCLES) and
//             the CMD_TIMEOUT pulse output; on expiry 16'hFFFF is sent.
//  Ports    : CLK, RST               - clock, async active-high reset
//             RX_P_DATA, RX_D_VLD    - received byte and its strobe
//             ALU_A/B/FUN/EN         - ALU operands, function, request
//             ALU_CLK_EN             - ALU clock-gate enable
//             ALU_OUT, ALU_OUT_VLD   - ALU result and its strobe
//             TX_P_DATA, TX_D_VLD    - byte to transmit and valid
//             TX_READY               - TX ready
//             CMD_DROP               - pulse when an RX byte is discarded
//             BUSY                   - high whenever not IDLE
//             CMD_TIMEOUT            - watchdog pulse (option only)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_seq
   import alu_cmd_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH  = 8,
   parameter int unsigned           FUN_WIDTH   = 4,
   parameter logic [DATA_WIDTH-1:0] OP_ALU_FULL = OPC_ALU_FULL,
   parameter logic [DATA_WIDTH-1:0] OP_ALU_FUN  = OPC_ALU_FUN
`ifdef CMD_TIMEOUT_EN
   ,
   parameter int unsigned           TIMEOUT_CYCLES = 16
`endif
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   output logic [DATA_WIDTH-1:0]   ALU_A,
   output logic [DATA_WIDTH-1:0]   ALU_B,
   output logic [FUN_WIDTH-1:0]    ALU_FUN,
   output logic                    ALU_EN,
   output logic                    ALU_CLK_EN,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   input  logic                    TX_READY,
   output logic                    CMD_DROP,
`ifdef CMD_TIMEOUT_EN
   output logic                    CMD_TIMEOUT,
`endif
   output logic                    BUSY
);

   state_t                  state;
   logic                    ser_load;
   logic [2*DATA_WIDTH-1:0] ser_data;
   logic                    ser_done;
   logic                    tx_fire;
   logic                    rx_unexpected;

`ifdef CMD_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wd_cnt;
   logic             wd_expire;

   assign wd_expire = (state == WAIT_RES) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   // A real result arriving on the expiry cycle takes precedence.
   assign ser_load  = (state == WAIT_RES) && (ALU_OUT_VLD || wd_expire);
   assign ser_data  = ALU_OUT_VLD ? ALU_OUT : '1;
`else
   assign ser_load  = (state == WAIT_RES) && ALU_OUT_VLD;
   assign ser_data  = ALU_OUT;
`endif

   assign tx_fire = TX_D_VLD && TX_READY;
   assign BUSY    = (state != IDLE);

   // Commands are not queued: any byte seen after the FUN byte is accepted
   // and before the sequencer returns to IDLE is discarded.
   assign rx_unexpected = RX_D_VLD && ((state == ISSUE) || (state == WAIT_RES) ||
                                       (state == SEND_LO) || (state == SEND_HI));

   // Enable is raised already in the FUN accept cycle so the gated ALU clock
   // is running before the ISSUE edge; decoded from state so reset clears it
   // without waiting for a clock.
   assign ALU_CLK_EN = ((state == GET_FUN) && RX_D_VLD) ||
                       (state == ISSUE) || (state == WAIT_RES);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         ALU_A    <= '0;
         ALU_B    <= '0;
         ALU_FUN  <= '0;
         ALU_EN   <= 1'b0;
         CMD_DROP <= 1'b0;
`ifdef CMD_TIMEOUT_EN
         wd_cnt      <= '0;
         CMD_TIMEOUT <= 1'b0;
`endif
      end else begin
         ALU_EN   <= 1'b0;
         CMD_DROP <= rx_unexpected;
`ifdef CMD_TIMEOUT_EN
         CMD_TIMEOUT <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (RX_D_VLD) begin
                  if (RX_P_DATA == OP_ALU_FULL) begin
                     state <= GET_A;
                  end else if (RX_P_DATA == OP_ALU_FUN) begin
                     state <= GET_FUN;
                  end else begin
                     CMD_DROP <= 1'b1;
                  end
               end
            end
            GET_A: begin
               if (RX_D_VLD) begin
                  ALU_A <= RX_P_DATA;
                  state <= GET_B;
               end
            end
            GET_B: begin
               if (RX_D_VLD) begin
                  ALU_B <= RX_P_DATA;
                  state <= GET_FUN;
               end
            end
            GET_FUN: begin
               if (RX_D_VLD) begin
                  ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                  ALU_EN  <= 1'b1;   // high for the single ISSUE cycle
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef CMD_TIMEOUT_EN
               wd_cnt <= '0;
`endif
               state <= WAIT_RES;
            end
            WAIT_RES: begin
               if (ser_load) begin
                  state <= SEND_LO;
`ifdef CMD_TIMEOUT_EN
                  CMD_TIMEOUT <= !ALU_OUT_VLD;
`endif
               end
`ifdef CMD_TIMEOUT_EN
               else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end
            SEND_LO: begin
               if (tx_fire) begin
                  state <= SEND_HI;
               end
            end
            SEND_HI: begin
               if (ser_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   alu_cmd_tx_ser #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tx_ser (
      .CLK       (CLK),
      .RST       (RST),
      .load      (ser_load),
      .load_data (ser_data),
      .tx_ready  (TX_READY),
      .tx_data   (TX_P_DATA),
      .tx_vld    (TX_D_VLD),
      .done      (ser_done)
   );

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cmd_seq
//  Purpose  : Self-checking directed bench for alu_cmd_seq. A small ALU
//             responder answers each ALU_EN with a programmed result; a
//             monitor records TX transfers, CMD_DROP pulses and ALU requests.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_cmd_seq;
   import alu_cmd_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  RX_P_DATA = '0;
   logic        RX_D_VLD = 1'b0;
   logic [7:0]  ALU_A, ALU_B;
   logic [3:0]  ALU_FUN;
   logic        ALU_EN, ALU_CLK_EN;
   logic [15:0] ALU_OUT = '0;
   logic        ALU_OUT_VLD = 1'b0;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        TX_READY = 1'b1;
   logic        CMD_DROP, BUSY;
`ifdef CMD_TIMEOUT_EN
   logic        CMD_TIMEOUT;
`endif

   int total = 0;
   int bad   = 0;

   logic [7:0]  tx_q[$];
   int          en_count = 0;
   int          drop_count = 0;
   logic [7:0]  cap_a = '0, cap_b = '0;
   logic [3:0]  cap_fun = '0;
   logic        cap_clk_en = 1'b0;
   logic [15:0] alu_resp = '0;
   int          alu_delay = 0;
   bit          alu_mute = 1'b0;

   alu_cmd_seq dut (
      .CLK         (CLK),
      .RST         (RST),
      .RX_P_DATA   (RX_P_DATA),
      .RX_D_VLD    (RX_D_VLD),
      .ALU_A       (ALU_A),
      .ALU_B       (ALU_B),
      .ALU_FUN     (ALU_FUN),
      .ALU_EN      (ALU_EN),
      .ALU_CLK_EN  (ALU_CLK_EN),
      .ALU_OUT     (ALU_OUT),
      .ALU_OUT_VLD (ALU_OUT_VLD),
      .TX_P_DATA   (TX_P_DATA),
      .TX_D_VLD    (TX_D_VLD),
      .TX_READY    (TX_READY),
      .CMD_DROP    (CMD_DROP),
`ifdef CMD_TIMEOUT_EN
      .CMD_TIMEOUT (CMD_TIMEOUT),
`endif
      .BUSY        (BUSY)
   );

   always #5 CLK = ~CLK;

   // Monitor: sampled on the falling edge, away from the active edge.
   initial forever begin
      @(negedge CLK);
      if (!RST) begin
         if (TX_D_VLD && TX_READY) tx_q.push_back(TX_P_DATA);
         if (CMD_DROP) drop_count++;
         if (ALU_EN) begin
            en_count++;
            cap_a      = ALU_A;
            cap_b      = ALU_B;
            cap_fun    = ALU_FUN;
            cap_clk_en = ALU_CLK_EN;
         end
      end
   end

   // ALU responder: result strobe alu_delay cycles after WAIT_RES is entered.
   initial forever begin
      @(negedge CLK);
      if (!RST && ALU_EN && !alu_mute) begin
         repeat (alu_delay) @(posedge CLK);
         @(posedge CLK);
         #1;
         ALU_OUT     = alu_resp;
         ALU_OUT_VLD = 1'b1;
         @(posedge CLK);
         #1;
         ALU_OUT_VLD = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLK);
      #1;
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(posedge CLK);
      #1;
      RX_D_VLD  = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (!BUSY && !TX_D_VLD) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge CLK);
      total++; if (ALU_A !== 8'h00)   begin bad++; $display("FAIL rst_alu_a got=%h want=00", ALU_A); end
      total++; if (ALU_B !== 8'h00)   begin bad++; $display("FAIL rst_alu_b got=%h want=00", ALU_B); end
      total++; if (ALU_FUN !== 4'h0)  begin bad++; $display("FAIL rst_alu_fun got=%h want=0", ALU_FUN); end
      total++; if (ALU_EN !== 1'b0)   begin bad++; $display("FAIL rst_alu_en got=%b want=0", ALU_EN); end
      total++; if (ALU_CLK_EN !== 1'b0) begin bad++; $display("FAIL rst_clk_en got=%b want=0", ALU_CLK_EN); end
      total++; if (TX_D_VLD !== 1'b0) begin bad++; $display("FAIL rst_tx_vld got=%b want=0", TX_D_VLD); end
      total++; if (TX_P_DATA !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%h want=00", TX_P_DATA); end
      total++; if (CMD_DROP !== 1'b0) begin bad++; $display("FAIL rst_drop got=%b want=0", CMD_DROP); end
      total++; if (BUSY !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b want=0", BUSY); end
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic test_full;
      int en0;
      int lat;
      bit ok;
      tx_q.delete();
      en0       = en_count;
      alu_resp  = 16'h000F;
      alu_delay = 0;
      TX_READY  = 1'b1;
      send_byte(8'hCC);
      send_byte(8'h0A);
      send_byte(8'h05);
      send_byte(8'h00);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         lat++;
         if (TX_D_VLD) break;
      end
      total++; if (lat != 3) begin bad++; $display("FAIL full_latency got=%0d want=3", lat); end
      wait_idle(50, ok);
      total++; if (!ok) begin bad++; $display("FAIL full_idle got=busy want=idle"); end
      total++; if (en_count - en0 != 1) begin bad++; $display("FAIL full_en_count got=%0d want=1", en_count - en0); end
      total++; if (cap_a !== 8'h0A) begin bad++; $display("FAIL full_a got=%h want=0a", cap_a); end
      total++; if (cap_b !== 8'h05) begin bad++; $display("FAIL full_b got=%h want=05", cap_b); end
      total++; if (cap_fun !== 4'h0) begin bad++; $display("FAIL full_fun got=%h want=0", cap_fun); end
      total++; if (cap_clk_en !== 1'b1) begin bad++; $display("FAIL full_clk_en got=%b want=1", cap_clk_en); end
      total++; if (ALU_CLK_EN !== 1'b0) begin bad++; $display("FAIL full_clk_en_idle got=%b want=0", ALU_CLK_EN); end
      total++; if (tx_q.size() != 2) begin bad++; $display("FAIL full_tx_count got=%0d want=2", tx_q.size()); end
      else begin
         total++; if (tx_q[0] !== 8'h0F) begin bad++; $display("FAIL full_tx0 got=%h want=0f", tx_q[0]); end
         total++; if (tx_q[1] !== 8'h00) begin bad++; $display("FAIL full_tx1 got=%h want=00", tx_q[1]); end
      end
   endtask

   task automatic test_reuse;
      int en0;
      bit ok;
      tx_q.delete();
      en0      = en_count;
      alu_resp = 16'h0032;
      send_byte(8'hDD);
      send_byte(8'h02);
      wait_idle(50, ok);
      total++; if (!ok) begin bad++; $display("FAIL reuse_idle got=busy want=idle"); end
      total++; if (en_count - en0 != 1) begin bad++; $display("FAIL reuse_en_count got=%0d want=1", en_count - en0); end
      total++; if (cap_a !== 8'h0A) begin bad++; $display("FAIL reuse_a got=%h want=0a", cap_a); end
      total++; if (cap_b !== 8'h05) begin bad++; $display("FAIL reuse_b got=%h want=05", cap_b); end
      total++; if (cap_fun !== 4'h2) begin bad++; $display("FAIL reuse_fun got=%h want=2", cap_fun); end
      total++; if (ALU_A !== 8'h0A) begin bad++; $display("FAIL reuse_a_port got=%h want=0a", ALU_A); end
      total++; if (tx_q.size() != 2) begin bad++; $display("FAIL reuse_tx_count got=%0d want=2", tx_q.size()); end
      else begin
         total++; if (tx_q[0] !== 8'h32) begin bad++; $display("FAIL reuse_tx0 got=%h want=32", tx_q[0]); end
         total++; if (tx_q[1] !== 8'h00) begin bad++; $display("FAIL reuse_tx1 got=%h want=00", tx_q[1]); end
      end
   endtask

   task automatic test_back_pressure;
      bit ok;
      bit seen;
      tx_q.delete();
      alu_resp = 16'h120F;
      TX_READY = 1'b0;
      send_byte(8'hCC);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h03);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (TX_D_VLD) begin seen = 1'b1; break; end
      end
      total++; if (!seen) begin bad++; $display("FAIL bp_vld_seen got=0 want=1"); end
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         total++;
         if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h0F) begin
            bad++; $display("FAIL bp_hold cycle=%0d got vld=%b data=%h want vld=1 data=0f", i, TX_D_VLD, TX_P_DATA);
         end
      end
      @(posedge CLK);
      #1;
      TX_READY = 1'b1;
      wait_idle(50, ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_idle got=busy want=idle"); end
      total++; if (tx_q.size() != 2) begin bad++; $display("FAIL bp_tx_count got=%0d want=2", tx_q.size()); end
      else begin
         total++; if (tx_q[0] !== 8'h0F) begin bad++; $display("FAIL bp_tx0 got=%h want=0f", tx_q[0]); end
         total++; if (tx_q[1] !== 8'h12) begin bad++; $display("FAIL bp_tx1 got=%h want=12", tx_q[1]); end
      end
   endtask

   task automatic test_drop;
      int d0;
      int en0;
      bit ok;
      tx_q.delete();
      d0  = drop_count;
      en0 = en_count;
      send_byte(8'h7E);
      repeat (2) @(negedge CLK);
      total++; if (drop_count - d0 != 1) begin bad++; $display("FAIL drop_idle_count got=%0d want=1", drop_count - d0); end
      total++; if (en_count != en0) begin bad++; $display("FAIL drop_idle_en got=%0d want=0", en_count - en0); end
      total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL drop_idle_busy got=%b want=0", BUSY); end
      // Byte arriving while the ALU result is outstanding
      alu_resp  = 16'h0003;
      alu_delay = 4;
      send_byte(8'hCC);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h55);
      wait_idle(50, ok);
      alu_delay = 0;
      total++; if (!ok) begin bad++; $display("FAIL drop_wait_idle got=busy want=idle"); end
      total++; if (drop_count - d0 != 2) begin bad++; $display("FAIL drop_wait_count got=%0d want=2", drop_count - d0); end
      total++; if (en_count - en0 != 1) begin bad++; $display("FAIL drop_wait_en got=%0d want=1", en_count - en0); end
      total++; if (tx_q.size() != 2) begin bad++; $display("FAIL drop_tx_count got=%0d want=2", tx_q.size()); end
      else begin
         total++; if (tx_q[0] !== 8'h03) begin bad++; $display("FAIL drop_tx0 got=%h want=03", tx_q[0]); end
         total++; if (tx_q[1] !== 8'h00) begin bad++; $display("FAIL drop_tx1 got=%h want=00", tx_q[1]); end
      end
   endtask

   task automatic test_timeout;
      tx_q.delete();
      alu_mute = 1'b1;
      send_byte(8'hCC);
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'h00);
`ifdef CMD_TIMEOUT_EN
      begin
         int  lat;
         bit  seen;
         bit  ok;
         lat  = 0;
         seen = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            lat++;
            if (CMD_TIMEOUT) begin seen = 1'b1; break; end
         end
         total++; if (!seen) begin bad++; $display("FAIL to_pulse got=0 want=1"); end
         total++; if (lat != 18) begin bad++; $display("FAIL to_latency got=%0d want=18", lat); end
         wait_idle(50, ok);
         total++; if (!ok) begin bad++; $display("FAIL to_idle got=busy want=idle"); end
         total++; if (tx_q.size() != 2) begin bad++; $display("FAIL to_tx_count got=%0d want=2", tx_q.size()); end
         else begin
            total++; if (tx_q[0] !== 8'hFF) begin bad++; $display("FAIL to_tx0 got=%h want=ff", tx_q[0]); end
            total++; if (tx_q[1] !== 8'hFF) begin bad++; $display("FAIL to_tx1 got=%h want=ff", tx_q[1]); end
         end
      end
`else
      begin
         int idle_seen;
         idle_seen = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (BUSY !== 1'b1 || TX_D_VLD !== 1'b0) idle_seen++;
         end
         total++; if (idle_seen != 0) begin bad++; $display("FAIL nto_busy_hold got=%0d want=0 cycles not waiting", idle_seen); end
         total++; if (tx_q.size() != 0) begin bad++; $display("FAIL nto_tx_count got=%0d want=0", tx_q.size()); end
         @(posedge CLK);
         #1;
         RST = 1'b1;
         @(posedge CLK);
         #1;
         RST = 1'b0;
      end
`endif
      alu_mute = 1'b0;
   endtask

   task automatic test_reset_mid_send;
      int en0;
      bit seen;
      bit ok;
      tx_q.delete();
      alu_resp = 16'h5A3C;
      TX_READY = 1'b0;
      send_byte(8'hCC);
      send_byte(8'h0A);
      send_byte(8'h05);
      send_byte(8'h00);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (TX_D_VLD) begin seen = 1'b1; break; end
      end
      total++; if (!seen) begin bad++; $display("FAIL rmid_vld_seen got=0 want=1"); end
      #2;
      RST = 1'b1;
      #1;
      total++; if (TX_D_VLD !== 1'b0) begin bad++; $display("FAIL rmid_tx_vld got=%b want=0", TX_D_VLD); end
      total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", BUSY); end
      total++; if (ALU_A !== 8'h00) begin bad++; $display("FAIL rmid_alu_a got=%h want=00", ALU_A); end
      total++; if (ALU_CLK_EN !== 1'b0) begin bad++; $display("FAIL rmid_clk_en got=%b want=0", ALU_CLK_EN); end
      @(posedge CLK);
      #1;
      RST      = 1'b0;
      TX_READY = 1'b1;
      // FUN-only command after reset must see cleared operands
      en0      = en_count;
      alu_resp = 16'h0102;
      send_byte(8'hDD);
      send_byte(8'h00);
      wait_idle(50, ok);
      total++; if (!ok) begin bad++; $display("FAIL rmid_idle got=busy want=idle"); end
      total++; if (en_count - en0 != 1) begin bad++; $display("FAIL rmid_en got=%0d want=1", en_count - en0); end
      total++; if (cap_a !== 8'h00 || cap_b !== 8'h00) begin bad++; $display("FAIL rmid_operands got=%h/%h want=00/00", cap_a, cap_b); end
      total++; if (tx_q.size() != 2) begin bad++; $display("FAIL rmid_tx_count got=%0d want=2", tx_q.size()); end
      else begin
         total++; if (tx_q[0] !== 8'h02) begin bad++; $display("FAIL rmid_tx0 got=%h want=02", tx_q[0]); end
         total++; if (tx_q[1] !== 8'h01) begin bad++; $display("FAIL rmid_tx1 got=%h want=01", tx_q[1]); end
      end
   endtask

   initial begin
      test_reset();
      test_full();
      test_reuse();
      test_back_pressure();
      test_drop();
      test_timeout();
      test_reset_mid_send();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
